// File: rtl/wm8978_i2c_responder_if.sv
// Bus-side signals of the WM8978 control-port responder: the I2C line levels in,
// the open-drain SDA pull and the decoded register-write outputs.
interface wm8978_i2c_responder_if;
    logic       scl_in;
    logic       sda_in;
    logic       sda_oe;
    logic       wr_valid;
    logic [6:0] wr_addr;
    logic [8:0] wr_data;
    logic       frame_err;
    logic       busy;

    modport slave (
        input  scl_in, sda_in,
        output sda_oe, wr_valid, wr_addr, wr_data, frame_err, busy
    );

    modport master (
        output scl_in, sda_in,
        input  sda_oe, wr_valid, wr_addr, wr_data, frame_err, busy
    );
endinterface

// File: rtl/wm8978_i2c_responder.sv
// Write-only I2C responder emulating the WM8978 control port: decodes
// {dev_addr, {reg[6:0], data[8]}, data[7:0]} frames into a one-cycle write strobe.
module wm8978_i2c_responder #(
    parameter logic [6:0] SLAVE_ADDR  = 7'h1a,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         sys_rst,
    wm8978_i2c_responder_if.slave        bus
);
    typedef enum logic [2:0] {
        IDLE, ADDR, ACK_A, BYTE0, ACK_0, BYTE1, ACK_1, IGNORE
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_det, stop_det, in_frame;

    state_e     state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] rx_byte;
    logic [6:0] addr_shadow_q, addr_shadow_d;
    logic       data8_q, data8_d;
    logic       sda_oe_q, sda_oe_d;
    logic       wr_valid_q, wr_valid_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [8:0] wr_data_q, wr_data_d;
    logic       frame_err_q, frame_err_d;
    logic       busy_q, busy_d;

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_det = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;
    assign rx_byte   = {shift_q[6:0], sda_s};
    assign in_frame  = (state_q inside {BYTE0, BYTE1, ACK_A, ACK_0, ACK_1}) ||
                       (state_q == ADDR && cnt_q != 3'd0);

    // NOTE: synchronizers reset to the idle-high bus level so leaving reset never fakes an edge.
    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            scl_sync_q    <= '1;
            sda_sync_q    <= '1;
            scl_prev_q    <= 1'b1;
            sda_prev_q    <= 1'b1;
            state_q       <= IDLE;
            cnt_q         <= '0;
            shift_q       <= '0;
            addr_shadow_q <= '0;
            data8_q       <= 1'b0;
            sda_oe_q      <= 1'b0;
            wr_valid_q    <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            frame_err_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            scl_sync_q    <= {scl_sync_q[SYNC_STAGES-2:0], bus.scl_in};
            sda_sync_q    <= {sda_sync_q[SYNC_STAGES-2:0], bus.sda_in};
            scl_prev_q    <= scl_s;
            sda_prev_q    <= sda_s;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            shift_q       <= shift_d;
            addr_shadow_q <= addr_shadow_d;
            data8_q       <= data8_d;
            sda_oe_q      <= sda_oe_d;
            wr_valid_q    <= wr_valid_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            frame_err_q   <= frame_err_d;
            busy_q        <= busy_d;
        end
    end

    // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        shift_d       = shift_q;
        addr_shadow_d = addr_shadow_q;
        data8_d       = data8_q;
        sda_oe_d      = sda_oe_q;
        wr_valid_d    = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        frame_err_d   = 1'b0;
        busy_d        = busy_q;

        if (start_det || stop_det) begin
            frame_err_d = in_frame;
            sda_oe_d    = 1'b0;
            cnt_d       = '0;
            busy_d      = start_det;
            state_d     = start_det ? ADDR : IDLE;
        end else begin
            unique case (state_q)
                IDLE: ;
                ADDR, BYTE0, BYTE1: begin
                    if (scl_rise) begin
                        shift_d = rx_byte;
                        cnt_d   = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == ADDR) begin
                                state_d = (rx_byte[7:1] == SLAVE_ADDR && !rx_byte[0]) ? ACK_A : IGNORE;
                            end else if (state_q == BYTE0) begin
                                addr_shadow_d = rx_byte[7:1];
                                data8_d       = rx_byte[0];
                                state_d       = ACK_0;
                            end else begin
                                state_d = ACK_1;
                            end
                        end
                    end
                end
                ACK_A, ACK_0, ACK_1: begin
                    // sda_oe doubles as the ACK phase: low = waiting for the slot, high = driving it.
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = 1'b1;
                            if (state_q == ACK_1) begin
                                wr_valid_d = 1'b1;
                                wr_addr_d  = addr_shadow_q;
                                wr_data_d  = {data8_q, shift_q};
                            end
                        end else begin
                            sda_oe_d = 1'b0;
                            state_d  = (state_q == ACK_A) ? BYTE0 :
                                       (state_q == ACK_0) ? BYTE1 : IGNORE;
                        end
                    end
                end
                IGNORE:  sda_oe_d = 1'b0;
                default: state_d  = IDLE;
            endcase
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.wr_valid  = wr_valid_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_wm8978_i2c_responder.sv
// Directed bench for wm8978_i2c_responder: bit-banged I2C master, scoreboard of
// expected register writes, and pulse counters on the strobes.
module tb_wm8978_i2c_responder;
    localparam int Q = 10;  // clk cycles per quarter SCL period

    typedef struct packed {
        logic [6:0] addr;
        logic [8:0] data;
    } wr_t;

    logic clk     = 1'b0;
    logic sys_rst = 1'b1;
    logic scl_drv = 1'b1;
    logic sda_drv = 1'b1;

    int   n_vec = 0;
    int   n_err = 0;
    wr_t  sb[$];
    wr_t  exp_w;
    int   vld_pulses = 0, vld_cycles = 0, ferr_pulses = 0, ferr_cycles = 0, spurious_chg = 0;
    logic vld_prev = 1'b0, ferr_prev = 1'b0;
    logic [6:0] addr_prev = '0;
    logic [8:0] data_prev = '0;

    wm8978_i2c_responder_if bus ();
    assign bus.scl_in = scl_drv;
    assign bus.sda_in = sda_drv & ~bus.sda_oe;

    wm8978_i2c_responder #(
        .SLAVE_ADDR (7'h1a),
        .SYNC_STAGES(2)
    ) dut (
        .clk    (clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Output monitor: scoreboard pops on wr_valid, strobe pulse/cycle counting.
    always @(negedge clk) begin
        if (!sys_rst) begin
            if (bus.wr_valid) begin
                vld_cycles++;
                if (!vld_prev) begin
                    vld_pulses++;
                    check("sb_pending", sb.size() != 0, 1);
                    if (sb.size() != 0) begin
                        exp_w = sb.pop_front();
                        check("wr_addr", bus.wr_addr, exp_w.addr);
                        check("wr_data", bus.wr_data, exp_w.data);
                    end
                end
            end else if (bus.wr_addr !== addr_prev || bus.wr_data !== data_prev) begin
                spurious_chg++;
            end
            if (bus.frame_err) begin
                ferr_cycles++;
                if (!ferr_prev) ferr_pulses++;
            end
        end
        vld_prev  = bus.wr_valid;
        ferr_prev = bus.frame_err;
        addr_prev = bus.wr_addr;
        data_prev = bus.wr_data;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic clear_counts();
        vld_pulses  = 0;
        vld_cycles  = 0;
        ferr_pulses = 0;
        ferr_cycles = 0;
    endtask

    task automatic expect_counts(input string t, input int vp, input int fp);
        check({t, "_wr_valid_pulses"}, vld_pulses, vp);
        check({t, "_wr_valid_cycles"}, vld_cycles, vp);
        check({t, "_frame_err_pulses"}, ferr_pulses, fp);
        check({t, "_frame_err_cycles"}, ferr_cycles, fp);
    endtask

    task automatic i2c_start();
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_drv = 1'b0; tick(Q);
        scl_drv = 1'b1; tick(Q);
        sda_drv = 1'b1; tick(2 * Q);
    endtask

    // Eight data bits MSB-first, then the ACK slot with SDA released by the master.
    task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string tag,
                             input bit rst_in_ack = 1'b0);
        for (int i = 7; i >= 0; i--) begin
            sda_drv = b[i]; tick(Q);
            scl_drv = 1'b1; tick(2 * Q);
            scl_drv = 1'b0; tick(Q);
        end
        sda_drv = 1'b1; tick(Q);
        scl_drv = 1'b1; tick(Q);
        #1;
        check(tag, bus.sda_oe, exp_ack);
        if (rst_in_ack) begin
            sys_rst = 1'b1;
            #1;
            check("rst_sda_oe", bus.sda_oe, 0);
            check("rst_busy", bus.busy, 0);
            check("rst_wr_addr", bus.wr_addr, 0);
            check("rst_wr_data", bus.wr_data, 0);
            check("rst_frame_err", bus.frame_err, 0);
            tick(2);
            sys_rst = 1'b0;
        end
        tick(Q);
        scl_drv = 1'b0; tick(Q);
    endtask

    initial begin
        tick(5);
        #1;
        check("reset_sda_oe", bus.sda_oe, 0);
        check("reset_wr_valid", bus.wr_valid, 0);
        check("reset_wr_addr", bus.wr_addr, 0);
        check("reset_wr_data", bus.wr_data, 0);
        check("reset_frame_err", bus.frame_err, 0);
        check("reset_busy", bus.busy, 0);
        sys_rst = 1'b0;
        tick(5);

        // Write reg 0x03 = 0x16D
        clear_counts();
        sb.push_back('{addr: 7'h03, data: 9'h16d});
        i2c_start();
        #1 check("t1_busy_start", bus.busy, 1);
        send_byte(8'h34, 1'b1, "t1_ack_addr");
        send_byte(8'h07, 1'b1, "t1_ack_byte0");
        send_byte(8'h6d, 1'b1, "t1_ack_byte1");
        i2c_stop();
        tick(5);
        #1 check("t1_busy_stop", bus.busy, 0);
        check("t1_wr_addr", bus.wr_addr, 7'h03);
        check("t1_wr_data", bus.wr_data, 9'h16d);
        expect_counts("t1", 1, 0);

        // Wrong device address: every byte NACKed
        clear_counts();
        i2c_start();
        send_byte(8'h36, 1'b0, "t2_nack_addr");
        send_byte(8'h07, 1'b0, "t2_nack_byte0");
        send_byte(8'h6d, 1'b0, "t2_nack_byte1");
        #1 check("t2_busy_before_stop", bus.busy, 1);
        i2c_stop();
        tick(5);
        #1 check("t2_busy_after_stop", bus.busy, 0);
        expect_counts("t2", 0, 0);

        // Read request is NACKed
        clear_counts();
        i2c_start();
        send_byte(8'h35, 1'b0, "t3_nack_read");
        send_byte(8'h00, 1'b0, "t3_nack_next");
        i2c_stop();
        tick(5);
        expect_counts("t3", 0, 0);

        // Truncated frame: STOP after byte 0
        clear_counts();
        i2c_start();
        send_byte(8'h34, 1'b1, "t4_ack_addr");
        send_byte(8'h07, 1'b1, "t4_ack_byte0");
        i2c_stop();
        tick(5);
        #1 check("t4_wr_addr_kept", bus.wr_addr, 7'h03);
        check("t4_wr_data_kept", bus.wr_data, 9'h16d);
        check("t4_busy", bus.busy, 0);
        expect_counts("t4", 0, 1);

        // Extra fourth byte is NACKed, write still decoded once
        clear_counts();
        sb.push_back('{addr: 7'h03, data: 9'h16d});
        i2c_start();
        send_byte(8'h34, 1'b1, "t5_ack_addr");
        send_byte(8'h07, 1'b1, "t5_ack_byte0");
        send_byte(8'h6d, 1'b1, "t5_ack_byte1");
        send_byte(8'hff, 1'b0, "t5_nack_extra");
        i2c_stop();
        tick(5);
        expect_counts("t5", 1, 0);

        // Reset while ACKing byte 0, then a full write of reg 0x31 = 0x002
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_ack_addr");
        send_byte(8'h07, 1'b1, "t6_ack_byte0_rst", 1'b1);
        tick(5);
        clear_counts();
        sb.push_back('{addr: 7'h31, data: 9'h002});
        i2c_start();
        send_byte(8'h34, 1'b1, "t6_ack_addr2");
        send_byte(8'h62, 1'b1, "t6_ack_byte0_2");
        send_byte(8'h02, 1'b1, "t6_ack_byte1_2");
        i2c_stop();
        tick(5);
        #1 check("t6_wr_addr", bus.wr_addr, 7'h31);
        check("t6_wr_data", bus.wr_data, 9'h002);
        expect_counts("t6", 1, 0);

        check("sb_drained", sb.size(), 0);
        check("spurious_output_change", spurious_chg, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
